// File: rtl/sram_port_pkg.sv
// Shared types and helpers for the OpenRAM 1RW port initiator.
package sram_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_WAIT,
        RMW_WR
    } state_e;

    localparam int unsigned RD_LATENCY = 2;

    function automatic logic [7:0] merge_byte(input logic       en,
                                              input logic [7:0] wbyte,
                                              input logic [7:0] rbyte);
        return en ? wbyte : rbyte;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; power-of-two depth, occupancy count exposed for admission control.
module sram_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_port_master.sv
// Valid/ready initiator for a 1RW OpenRAM macro: reads, full writes, and RMW for byte-masked writes.
module sram_port_master
    import sram_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    state_e                  r_state;
    logic                    r_live;
    logic [RD_LATENCY-1:0]   r_tag_v;
    logic [RD_LATENCY-1:0]   r_tag_rmw;
    logic                    r_csb;
    logic                    r_web;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_wmask;

    logic [CW-1:0]           w_count;
    logic                    w_empty;
    logic [SW-1:0]           w_inflight;
    logic                    w_rd_slot;
    logic                    w_open;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_merged;

    // Reads reserve a FIFO slot at admission so an in-flight capture can never overflow.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            if (r_tag_v[i] && !r_tag_rmw[i]) w_inflight = w_inflight + SW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_merged[8*i +: 8] = merge_byte(r_wmask[i], r_wdata[8*i +: 8], sram_dout0[8*i +: 8]);
        end
    end

    assign w_rd_slot = (SW'(w_count) + w_inflight) < SW'(RSP_DEPTH);
    assign w_open    = r_live && (r_state == IDLE || r_state == RMW_WR);
    assign req_ready = w_open && (req_we || w_rd_slot);
    assign w_accept  = req_valid && req_ready;
    assign w_push    = r_tag_v[RD_LATENCY-1] && !r_tag_rmw[RD_LATENCY-1];
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_valid = !w_empty;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_live    <= 1'b0;
            r_tag_v   <= '0;
            r_tag_rmw <= '0;
            r_csb     <= 1'b1;
            r_web     <= 1'b1;
            r_addr    <= '0;
            r_din     <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
        end else begin
            r_live    <= 1'b1;
            r_tag_v   <= {r_tag_v[RD_LATENCY-2:0], 1'b0};
            r_tag_rmw <= {r_tag_rmw[RD_LATENCY-2:0], 1'b0};
            r_csb     <= 1'b1;
            r_web     <= 1'b1;
            unique case (r_state)
                RMW_RD: r_state <= RMW_WAIT;
                RMW_WAIT: begin
                    r_state <= RMW_WR;
                    r_csb   <= 1'b0;
                    r_web   <= 1'b0;
                    r_din   <= w_merged;
                end
                default: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        if (!req_we) begin
                            r_csb        <= 1'b0;
                            r_addr       <= req_addr;
                            r_tag_v[0]   <= 1'b1;
                            r_tag_rmw[0] <= 1'b0;
                        end else if (&req_wmask) begin
                            r_csb  <= 1'b0;
                            r_web  <= 1'b0;
                            r_addr <= req_addr;
                            r_din  <= req_wdata;
                        end else if (|req_wmask) begin
                            r_state      <= RMW_RD;
                            r_csb        <= 1'b0;
                            r_addr       <= req_addr;
                            r_wdata      <= req_wdata;
                            r_wmask      <= req_wmask;
                            r_tag_v[0]   <= 1'b1;
                            r_tag_rmw[0] <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign sram_csb0  = r_csb;
    assign sram_web0  = r_web;
    assign sram_addr0 = r_addr;
    assign sram_din0  = r_din;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk     (clk0),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (sram_dout0),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_count (w_count),
        .o_empty (w_empty)
    );

endmodule
